// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: drains the UART receiver's single-byte buffer into a DEPTH-entry
// show-ahead FIFO, keeps sticky error status and raises a level/timeout interrupt.
// Optional feature: define UART_RX_TIMEOUT_EN to build the idle-timeout counter
// that drives status[2]; without it status[2] is tied to 0.

module uart_rx_ctrl #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned THRESH  = 8,
    parameter int unsigned TIMEOUT = 640
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_data_valid,
    input  logic                       rx_overrun,
    input  logic                       rx_framing_err,
    output logic                       host_ready,
    output logic                       clear_framing_err,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic [2:0]                 status,
    input  logic [2:0]                 status_clr,
    output logic                       irq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam logic [LW-1:0] DepthL  = LW'(DEPTH);
    localparam logic [LW-1:0] ThreshL = LW'(THRESH);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StGap
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      mem_q [DEPTH];
    logic [2:0]      status_q, status_d;
    logic            wr_en;
    logic            pop;
    logic            tmo_hit;

    // The byte is committed in the ACK cycle; pops on an empty FIFO are dropped.
    assign wr_en = (state_q == StAck);
    assign pop   = rd_en && (level_q != '0);

    // Ingress state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Ingress next state: acknowledge only when the registered level shows room,
    // then skip one cycle while the receiver reloads its buffer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rx_data_valid && (level_q < DepthL)) begin
                    state_d = StAck;
                end
            end
            StAck:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Occupancy next state.
    always_comb begin
        level_d = level_q;
        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    // FIFO storage; a reset during ACK discards the byte.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TimeoutL = TW'(TIMEOUT);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Idle counter: cleared by any FIFO activity or an empty FIFO, saturates so
    // the timeout fires only once per idle period.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (wr_en || pop || (level_q == '0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TimeoutL) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = (tmo_cnt_d == TimeoutL) && (tmo_cnt_q != TimeoutL);

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    // Sticky status next state; a set in the same cycle beats the clear.
    always_comb begin
        status_d    = status_q;
        status_d[0] = rx_overrun     | (status_q[0] & ~status_clr[0]);
        status_d[1] = rx_framing_err | (status_q[1] & ~status_clr[1]);
        status_d[2] = tmo_hit        | (status_q[2] & ~status_clr[2]);
    end

    // Status register.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign host_ready        = (state_q == StAck);
    // Forwarded in the same cycle as the host's clear so the receiver drops its flag.
    assign clear_framing_err = status_clr[1] & status_q[1];
    assign rd_valid          = (level_q != '0);
    assign rd_data           = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign level             = level_q;
    assign status            = status_q;
    assign irq               = (level_q >= ThreshL) | status_q[2];

endmodule
